// File: rtl/scan_sched_pkg.sv
// Shared types, defaults and helpers for the laser shot scheduler.
// Holds the FSM state encoding, timing defaults and the angular window test.
package scan_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ZERO,
        ST_ARMED,
        ST_CHARGE,
        ST_FIRE,
        ST_RX
    } sched_state_t;

    localparam int DEF_FIRE_W   = 4;
    localparam int DEF_RX_W     = 200;
    localparam int DEF_ZERO_TMO = 5_000_000;

    // Encoder resolutions in use across the scanner family.
    localparam int ANGLES_3600 = 3600;
    localparam int ANGLES_7200 = 7200;
    localparam int ANGLES_1800 = 1800;
    localparam int ANGLES_1080 = 1080;

    // Inclusive window; start > stop means the window wraps through index 0.
    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] start,
                                       input logic [15:0] stop);
        if (start <= stop) begin
            return (a >= start) && (a <= stop);
        end
        return (a >= start) || (a <= stop);
    endfunction

endpackage

// File: rtl/sched_phase_timer.sv
// Loadable 10-bit down-counter shared by the CHARGE, FIRE and RX phases.
// o_done is high during the final cycle of a loaded duration.
module sched_phase_timer (
    input  logic       i_clk_50m,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [9:0] i_load_val,
    output logic       o_done
);

    logic [9:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 10'd1;
        end
    end

    assign o_done = (r_cnt == 10'd1);

endmodule

// File: rtl/scan_fire_scheduler.sv
// One charge -> fire -> receive shot per in-window encoder step, with frame supervision.
// Optional SCAN_STATS_EN adds per-frame shot counters; FSM behaviour is unchanged.
module scan_fire_scheduler
    import scan_sched_pkg::*;
#(
    parameter int FIRE_W   = DEF_FIRE_W,
    parameter int RX_W     = DEF_RX_W,
    parameter int ZERO_TMO = DEF_ZERO_TMO
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_scan_en,
    input  logic        i_motor_state,
    input  logic        i_angle_sync,
    input  logic        i_zero_sign,
    input  logic [15:0] i_zero_angle,
    input  logic [15:0] i_start_angle,
    input  logic [15:0] i_stop_angle,
    input  logic [9:0]  i_charge_cyc,
    input  logic        i_clr,
    output logic        o_laser_mode,
    output logic        o_charge,
    output logic        o_fire,
    output logic        o_rx_window,
    output logic [15:0] o_shot_angle,
    output logic        o_frame_start,
    output logic        o_overrun,
    output logic        o_sync_lost
`ifdef SCAN_STATS_EN
    ,
    output logic [15:0] o_shot_cnt,
    output logic [15:0] o_last_frame_shots
`endif
);

    localparam logic [23:0] WD_LIMIT = 24'(ZERO_TMO - 1);

    sched_state_t r_state;
    sched_state_t w_next;

    logic        w_abort;
    logic        w_wd_expire;
    logic        w_frame_evt;
    logic        w_shot;
    logic        w_overrun_set;
    logic        w_sync_lost_set;
    logic        w_tmr_load;
    logic [9:0]  w_tmr_val;
    logic        w_tmr_done;
    logic [9:0]  w_charge_eff;
    logic [23:0] r_wd;

    logic        r_laser_mode;
    logic        r_charge;
    logic        r_fire;
    logic        r_rx_window;
    logic [15:0] r_shot_angle;
    logic        r_frame_start;
    logic        r_overrun;
    logic        r_sync_lost;

    assign w_charge_eff = (i_charge_cyc == 10'd0) ? 10'd1 : i_charge_cyc;
    assign w_abort      = !(i_scan_en && i_motor_state);
    // A zero mark in the expiry cycle resets the watchdog instead of tripping it.
    assign w_wd_expire  = (r_state != ST_IDLE) && !i_zero_sign && (r_wd == WD_LIMIT);

    sched_phase_timer u_timer (
        .i_clk_50m (i_clk_50m),
        .i_rst_n   (i_rst_n),
        .i_load    (w_tmr_load),
        .i_load_val(w_tmr_val),
        .o_done    (w_tmr_done)
    );

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next          = r_state;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;
        w_shot          = 1'b0;
        w_frame_evt     = i_zero_sign && (r_state != ST_IDLE);
        w_overrun_set   = i_angle_sync &&
                          (r_state inside {ST_CHARGE, ST_FIRE, ST_RX});
        w_sync_lost_set = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_abort) w_next = ST_WAIT_ZERO;
            end
            ST_WAIT_ZERO: begin
                if (i_zero_sign) w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (i_angle_sync && in_window(i_zero_angle, i_start_angle, i_stop_angle)) begin
                    w_next     = ST_CHARGE;
                    w_shot     = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_charge_eff;
                end
            end
            ST_CHARGE: begin
                if (w_tmr_done) begin
                    w_next     = ST_FIRE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = 10'(FIRE_W);
                end
            end
            ST_FIRE: begin
                if (w_tmr_done) begin
                    w_next     = ST_RX;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = 10'(RX_W);
                end
            end
            ST_RX: begin
                if (w_tmr_done) w_next = ST_ARMED;
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_wd_expire) begin
            w_next          = ST_WAIT_ZERO;
            w_sync_lost_set = 1'b1;
            w_shot          = 1'b0;
            w_tmr_load      = 1'b0;
        end

        if (w_abort) begin
            w_next          = ST_IDLE;
            w_frame_evt     = 1'b0;
            w_shot          = 1'b0;
            w_overrun_set   = 1'b0;
            w_sync_lost_set = 1'b0;
            w_tmr_load      = 1'b0;
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else if (w_abort || (r_state == ST_IDLE) || i_zero_sign || w_wd_expire) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 24'd1;
        end
    end

    // Outputs are decoded from the next state so they are flops aligned with r_state.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_laser_mode  <= 1'b0;
            r_charge      <= 1'b0;
            r_fire        <= 1'b0;
            r_rx_window   <= 1'b0;
            r_shot_angle  <= '0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_sync_lost   <= 1'b0;
        end else begin
            r_laser_mode  <= (w_next != ST_IDLE);
            r_charge      <= (w_next == ST_CHARGE);
            r_fire        <= (w_next == ST_FIRE);
            r_rx_window   <= (w_next == ST_RX);
            r_frame_start <= w_frame_evt;
            if (w_shot) r_shot_angle <= i_zero_angle;
            if (w_overrun_set)   r_overrun   <= 1'b1;
            else if (i_clr)      r_overrun   <= 1'b0;
            if (w_sync_lost_set) r_sync_lost <= 1'b1;
            else if (i_clr)      r_sync_lost <= 1'b0;
        end
    end

    assign o_laser_mode  = r_laser_mode;
    assign o_charge      = r_charge;
    assign o_fire        = r_fire;
    assign o_rx_window   = r_rx_window;
    assign o_shot_angle  = r_shot_angle;
    assign o_frame_start = r_frame_start;
    assign o_overrun     = r_overrun;
    assign o_sync_lost   = r_sync_lost;

`ifdef SCAN_STATS_EN
    logic [15:0] r_shot_cnt;
    logic [15:0] r_last_frame_shots;

    // A shot accepted together with the zero mark belongs to the new frame.
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shot_cnt         <= '0;
            r_last_frame_shots <= '0;
        end else if (w_frame_evt) begin
            r_last_frame_shots <= r_shot_cnt;
            r_shot_cnt         <= w_shot ? 16'd1 : 16'd0;
        end else if (w_shot && (r_shot_cnt != 16'hFFFF)) begin
            r_shot_cnt <= r_shot_cnt + 16'd1;
        end
    end

    assign o_shot_cnt         = r_shot_cnt;
    assign o_last_frame_shots = r_last_frame_shots;
`endif

endmodule

// File: tb/tb_scan_fire_scheduler.sv
// Directed bench for scan_fire_scheduler; watchdog shortened to keep runtime small.
// Define SCAN_STATS_EN for both bench and RTL to exercise the frame shot counters.
module tb_scan_fire_scheduler;

    localparam int TB_ZERO_TMO = 8000;

    logic        i_clk_50m = 1'b0;
    logic        i_rst_n;
    logic        i_scan_en;
    logic        i_motor_state;
    logic        i_angle_sync;
    logic        i_zero_sign;
    logic [15:0] i_zero_angle;
    logic [15:0] i_start_angle;
    logic [15:0] i_stop_angle;
    logic [9:0]  i_charge_cyc;
    logic        i_clr;
    logic        o_laser_mode;
    logic        o_charge;
    logic        o_fire;
    logic        o_rx_window;
    logic [15:0] o_shot_angle;
    logic        o_frame_start;
    logic        o_overrun;
    logic        o_sync_lost;
`ifdef SCAN_STATS_EN
    logic [15:0] o_shot_cnt;
    logic [15:0] o_last_frame_shots;
`endif

    int n_vec = 0;
    int n_err = 0;

    scan_fire_scheduler #(.ZERO_TMO(TB_ZERO_TMO)) dut (
        .i_clk_50m    (i_clk_50m),
        .i_rst_n      (i_rst_n),
        .i_scan_en    (i_scan_en),
        .i_motor_state(i_motor_state),
        .i_angle_sync (i_angle_sync),
        .i_zero_sign  (i_zero_sign),
        .i_zero_angle (i_zero_angle),
        .i_start_angle(i_start_angle),
        .i_stop_angle (i_stop_angle),
        .i_charge_cyc (i_charge_cyc),
        .i_clr        (i_clr),
        .o_laser_mode (o_laser_mode),
        .o_charge     (o_charge),
        .o_fire       (o_fire),
        .o_rx_window  (o_rx_window),
        .o_shot_angle (o_shot_angle),
        .o_frame_start(o_frame_start),
        .o_overrun    (o_overrun),
        .o_sync_lost  (o_sync_lost)
`ifdef SCAN_STATS_EN
        ,
        .o_shot_cnt        (o_shot_cnt),
        .o_last_frame_shots(o_last_frame_shots)
`endif
    );

    always #10 i_clk_50m = ~i_clk_50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge i_clk_50m);
        #1;
    endtask

    task automatic pulse_sync(input logic [15:0] a);
        i_zero_angle = a;
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
    endtask

    task automatic pulse_zero();
        i_zero_sign = 1'b1;
        tick();
        i_zero_sign = 1'b0;
    endtask

    function automatic logic gate(input int sel);
        case (sel)
            0:       return o_charge;
            1:       return o_fire;
            default: return o_rx_window;
        endcase
    endfunction

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (gate(sel) && n < 1100) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_shot_end();
        int n = 0;
        while ((o_charge || o_fire || o_rx_window) && n < 3000) begin
            n++;
            tick();
        end
        check("shot_end_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int len;
        int n;

        i_rst_n       = 1'b0;
        i_scan_en     = 1'b1;
        i_motor_state = 1'b1;
        i_angle_sync  = 1'b0;
        i_zero_sign   = 1'b0;
        i_zero_angle  = '0;
        i_start_angle = 16'd0;
        i_stop_angle  = 16'd3599;
        i_charge_cyc  = 10'd150;
        i_clr         = 1'b0;

        // Reset holds every output low even with scan enabled.
        repeat (3) tick();
        check("rst_laser_mode", 32'(o_laser_mode), 32'd0);
        check("rst_gates", {29'd0, o_charge, o_fire, o_rx_window}, 32'd0);
        check("rst_flags", {29'd0, o_frame_start, o_overrun, o_sync_lost}, 32'd0);
        check("rst_shot_angle", 32'(o_shot_angle), 32'd0);
        i_rst_n = 1'b1;

        // Test 1: basic shot timing.
        tick();
        check("t1_laser_mode_on", 32'(o_laser_mode), 32'd1);
        pulse_zero();
        check("t1_frame_start", 32'(o_frame_start), 32'd1);
        tick();
        check("t1_frame_start_1cyc", 32'(o_frame_start), 32'd0);
        pulse_sync(16'd100);
        check("t1_charge_latency", 32'(o_charge), 32'd1);
        check("t1_shot_angle", 32'(o_shot_angle), 32'd100);
        count_high(0, len);
        check("t1_charge_len", 32'(len), 32'd150);
        check("t1_fire_follows", 32'(o_fire), 32'd1);
        count_high(1, len);
        check("t1_fire_len", 32'(len), 32'd4);
        check("t1_rx_follows", 32'(o_rx_window), 32'd1);
        count_high(2, len);
        check("t1_rx_len", 32'(len), 32'd200);
        check("t1_armed_gates", {29'd0, o_charge, o_fire, o_rx_window}, 32'd0);
        check("t1_armed_laser", 32'(o_laser_mode), 32'd1);

        // Test 2: wrapping window 3500..50, charge 0 treated as 1.
        i_start_angle = 16'd3500;
        i_stop_angle  = 16'd50;
        i_charge_cyc  = 10'd0;
        pulse_sync(16'd3499);
        check("t2_3499_rejected", 32'(o_charge), 32'd0);
        tick();
        pulse_sync(16'd3550);
        check("t2_3550_charge", 32'(o_charge), 32'd1);
        check("t2_3550_angle", 32'(o_shot_angle), 32'd3550);
        tick();
        check("t2_charge0_is_1", 32'(o_fire), 32'd1);
        wait_shot_end();
        pulse_sync(16'd20);
        check("t2_20_charge", 32'(o_charge), 32'd1);
        check("t2_20_angle", 32'(o_shot_angle), 32'd20);
        wait_shot_end();
        pulse_sync(16'd51);
        check("t2_51_rejected", 32'(o_charge), 32'd0);
        check("t2_51_angle_kept", 32'(o_shot_angle), 32'd20);
        check("t2_no_overrun", 32'(o_overrun), 32'd0);

        // Test 3: overrun during RX, clear, set-beats-clear.
        i_start_angle = 16'd0;
        i_stop_angle  = 16'd3599;
        i_charge_cyc  = 10'd300;
        tick();
        pulse_sync(16'd100);
        repeat (439) tick();
        pulse_sync(16'd200);
        check("t3_in_rx", 32'(o_rx_window), 32'd1);
        check("t3_overrun_set", 32'(o_overrun), 32'd1);
        check("t3_angle_kept", 32'(o_shot_angle), 32'd100);
        i_clr = 1'b1;
        tick();
        check("t3_overrun_clr", 32'(o_overrun), 32'd0);
        i_angle_sync = 1'b1;
        tick();
        i_angle_sync = 1'b0;
        check("t3_set_beats_clr", 32'(o_overrun), 32'd1);
        tick();
        i_clr = 1'b0;
        check("t3_overrun_clr2", 32'(o_overrun), 32'd0);
        check("t3_shot_continues", 32'(o_rx_window), 32'd1);
        wait_shot_end();

        // Test 4: zero-mark watchdog.
        pulse_zero();
        check("t4_frame_in_armed", 32'(o_frame_start), 32'd1);
        repeat (TB_ZERO_TMO - 20) tick();
        check("t4_not_yet_lost", 32'(o_sync_lost), 32'd0);
        repeat (40) tick();
        check("t4_sync_lost", 32'(o_sync_lost), 32'd1);
        check("t4_laser_stays", 32'(o_laser_mode), 32'd1);
        i_charge_cyc = 10'd1;
        pulse_sync(16'd100);
        check("t4_wait_zero_no_shot", 32'(o_charge), 32'd0);

        // Test 5: motor drop during FIRE aborts immediately.
        pulse_zero();
        check("t5_frame_start", 32'(o_frame_start), 32'd1);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        check("t5_sync_lost_clr", 32'(o_sync_lost), 32'd0);
        pulse_sync(16'd10);
        n = 0;
        while (!o_fire && n < 500) begin
            n++;
            tick();
        end
        check("t5_reach_fire", 32'(o_fire), 32'd1);
        tick();
        i_motor_state = 1'b0;
        tick();
        check("t5_fire_drop", 32'(o_fire), 32'd0);
        check("t5_laser_off", 32'(o_laser_mode), 32'd0);
        check("t5_no_rx", 32'(o_rx_window), 32'd0);
        i_motor_state = 1'b1;
        tick();
        check("t5_relaunch", 32'(o_laser_mode), 32'd1);
        pulse_sync(16'd10);
        check("t5_wait_zero_again", 32'(o_charge), 32'd0);

`ifdef SCAN_STATS_EN
        // Test 6: per-frame shot statistics.
        pulse_zero();
        check("t6_cnt_cleared", 32'(o_shot_cnt), 32'd0);
        for (int i = 0; i < 25; i++) begin
            pulse_sync(16'(i * 10));
            wait_shot_end();
        end
        check("t6_shot_cnt_25", 32'(o_shot_cnt), 32'd25);
        pulse_zero();
        check("t6_last_frame_25", 32'(o_last_frame_shots), 32'd25);
        check("t6_shot_cnt_0", 32'(o_shot_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
